act_addr_gen: RTL

Parametrised activation-memory address generator for the three-bank activation buffer. In CONV mode it streams a 3-row sliding window over an input feature map of runtime width and height. It rotates bank-to-row mapping, so each input row is read from memory exactly once per output row it contributes to. In FC mode it streams a linear vector read. It sits between the layer controller (start/mode/config) and the three activation SRAM banks, and drives the row mux in front of the register file.

---
 rtl/act_pkg.sv | 20 ++
 rtl/act_win_cnt.sv | 54 +++++
 rtl/act_addr_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the activation-memory address generator.
//   NUM_BANKS   - number of activation SRAM banks
//   ACT_ADDR_W  - default per-bank activation memory address width
//   MODE_*      - conv_or_fc mode codes
//   act_state_e - address generator FSM state encoding
package act_pkg;

    localparam int unsigned NUM_BANKS  = 3;
    localparam int unsigned ACT_ADDR_W = 13;

    localparam logic [1:0] MODE_CONV = 2'b01;
    localparam logic [1:0] MODE_FC   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FC   = 2'd2
    } act_state_e;

endpackage

// File: rtl/act_win_cnt.sv
// act_win_cnt: nested column / output-row counter for the CONV sliding window.
// The counter holds the position of the read currently presented on the bus.
//   clk, rst_n  - clock, async active-low reset
//   clr         - restart at col = 0, row = 0
//   step        - advance one position (ignored while stall is high)
//   stall       - hold all counters
//   width, rows - latched feature-map width W and height H
//   col         - current column
//   row_end_c   - current column is W-1
//   last_c      - current position is the final read (row H-3, col W-1)
module act_win_cnt
    import act_pkg::*;
#(
    parameter int unsigned DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic             stall,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] rows,
    output logic [DIM_W-1:0] col,
    output logic             row_end_c,
    output logic             last_c
);

    logic [DIM_W-1:0] orow;

    // Terminal flags; rows >= 3 is guaranteed whenever the counter is in use
    always_comb begin
        row_end_c = (col == width - DIM_W'(1));
        last_c    = row_end_c && (orow == rows - DIM_W'(3));
    end

    // Column counter wraps into the output-row counter at row end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            orow <= '0;
        end else if (clr) begin
            col  <= '0;
            orow <= '0;
        end else if (step && !stall) begin
            if (row_end_c) begin
                col  <= '0;
                orow <= orow + DIM_W'(1);
            end else begin
                col  <= col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/act_addr_gen.sv
// act_addr_gen: address generator for the three-bank activation buffer.
// CONV streams a 3-row sliding window with rotating bank-to-row mapping;
// FC streams a linear read with all banks at the same index.
//   clk, rst_n          - clock, async active-low reset
//   act_load            - start pulse (honoured only in IDLE)
//   conv_or_fc          - 01 CONV, 10 FC, other codes ignored
//   cfg_width/cfg_rows  - feature-map width W and height H
//   cfg_fc_len          - FC read count N
//   stall               - freeze: no read issued, counters hold
//   abort               - synchronous return to IDLE, outputs cleared
//   act_mem_addr_1/2/3  - bank 0/1/2 read addresses
//   en_act_mem          - read enable common to all banks
//   row_sel             - bank feeding register-file row 0
//   busy                - high while streaming
//   go_next_stage       - one-cycle done pulse
module act_addr_gen
    import act_pkg::*;
#(
    parameter int unsigned ADDR_W = ACT_ADDR_W,
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned LEN_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              act_load,
    input  logic [1:0]        conv_or_fc,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [LEN_W-1:0]  cfg_fc_len,
    input  logic              stall,
    input  logic              abort,
    output logic [ADDR_W-1:0] act_mem_addr_1,
    output logic [ADDR_W-1:0] act_mem_addr_2,
    output logic [ADDR_W-1:0] act_mem_addr_3,
    output logic              en_act_mem,
    output logic [1:0]        row_sel,
    output logic              busy,
    output logic              go_next_stage
);

    act_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q [NUM_BANKS];
    logic [ADDR_W-1:0] addr_d [NUM_BANKS];
    logic [ADDR_W-1:0] base_q [NUM_BANKS];
    logic [ADDR_W-1:0] base_d [NUM_BANKS];
    logic              en_q, en_d;
    logic [1:0]        row_sel_q, row_sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] col_nxt;

    logic              cnt_clr, cnt_step;
    logic [DIM_W-1:0]  col;
    logic              row_end_c, last_c;
    logic              start_conv_c, start_fc_c, degen_c, fc_last_c;

    act_win_cnt #(.DIM_W(DIM_W)) u_win_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .step      (cnt_step),
        .stall     (stall),
        .width     (width_q),
        .rows      (rows_q),
        .col       (col),
        .row_end_c (row_end_c),
        .last_c    (last_c)
    );

    // Start decode and FC terminal index
    always_comb begin
        start_conv_c = act_load && (conv_or_fc == MODE_CONV) && (cfg_rows >= DIM_W'(3));
        start_fc_c   = act_load && (conv_or_fc == MODE_FC) && (cfg_fc_len != '0);
        degen_c      = act_load && (((conv_or_fc == MODE_CONV) && (cfg_rows < DIM_W'(3))) ||
                                    ((conv_or_fc == MODE_FC) && (cfg_fc_len == '0)));
        fc_last_c    = (idx_q == len_q - LEN_W'(1));
        idx_nxt      = idx_q + LEN_W'(1);
        col_nxt      = ADDR_W'(col) + ADDR_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_conv_c)    state_d = ST_CONV;
                    else if (start_fc_c) state_d = ST_FC;
                end
                ST_CONV: if (last_c)    state_d = ST_IDLE;
                ST_FC:   if (fc_last_c) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values; done completes even if stall is high
    always_comb begin
        addr_d    = addr_q;
        base_d    = base_q;
        en_d      = 1'b0;
        row_sel_d = row_sel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        width_d   = width_q;
        rows_d    = rows_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_clr   = 1'b0;
        cnt_step  = 1'b0;
        if (abort) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                addr_d[b] = '0;
                base_d[b] = '0;
            end
            row_sel_d = '0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_conv_c) begin
                        width_d = cfg_width;
                        rows_d  = cfg_rows;
                        cnt_clr = 1'b1;
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            addr_d[b] = '0;
                            base_d[b] = '0;
                        end
                        en_d      = 1'b1;
                        row_sel_d = '0;
                        busy_d    = 1'b1;
                    end else if (start_fc_c) begin
                        len_d = cfg_fc_len;
                        idx_d = '0;
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            addr_d[b] = '0;
                        end
                        en_d      = 1'b1;
                        row_sel_d = '0;
                        busy_d    = 1'b1;
                    end else if (degen_c) begin
                        done_d = 1'b1;
                    end
                end
                ST_CONV: begin
                    if (last_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                        if (!stall) begin
                            en_d = 1'b1;
                            // Row end: the bank holding the oldest row moves down by W
                            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                                if (row_end_c) begin
                                    if (row_sel_q == 2'(b)) begin
                                        base_d[b] = base_q[b] + ADDR_W'(width_q);
                                    end
                                    addr_d[b] = base_d[b];
                                end else begin
                                    addr_d[b] = base_q[b] + col_nxt;
                                end
                            end
                            if (row_end_c) begin
                                row_sel_d = (row_sel_q == 2'd2) ? 2'd0 : row_sel_q + 2'd1;
                            end
                        end
                    end
                end
                ST_FC: begin
                    if (fc_last_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else if (!stall) begin
                        idx_d = idx_nxt;
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            addr_d[b] = ADDR_W'(idx_nxt);
                        end
                        en_d = 1'b1;
                    end
                end
                default: busy_d = 1'b0;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                addr_q[b] <= '0;
                base_q[b] <= '0;
            end
            en_q      <= 1'b0;
            row_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            width_q   <= '0;
            rows_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                addr_q[b] <= addr_d[b];
                base_q[b] <= base_d[b];
            end
            en_q      <= en_d;
            row_sel_q <= row_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            width_q   <= width_d;
            rows_q    <= rows_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
        end
    end

    assign act_mem_addr_1 = addr_q[0];
    assign act_mem_addr_2 = addr_q[1];
    assign act_mem_addr_3 = addr_q[2];
    assign en_act_mem     = en_q;
    assign row_sel        = row_sel_q;
    assign busy           = busy_q;
    assign go_next_stage  = done_q;

endmodule
